// File: rtl/if_prefetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_stage_if
// Purpose  : Instruction-memory request/response bus (req/gnt/rvalid).
// Revision : 1.0 - initial release
// ============================================================================
interface if_prefetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/if_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_stage
// Purpose  : Instruction fetch with DEPTH-entry prefetch queue, credit-limited
//            in-order memory requests and branch flush with stale-drop.
//            Optional macro IF_BYPASS_EN: same-cycle bypass into an empty queue.
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_OUT  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       branchTaken,
  input  logic [ADDR_W-1:0]          branchAddr,
  input  logic                       freeze,
  if_prefetch_stage_if.master        imem,
  output logic                       valid,
  output logic [ADDR_W-1:0]          pc,
  output logic [DATA_W-1:0]          instruction,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(MAX_OUT+1);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;
  localparam logic [ADDR_W-1:0] INSN_BYTES = ADDR_W'(4);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q,  resp_pc_d;
  logic [IW-1:0]     inflight_q, inflight_d;
  logic [IW-1:0]     drop_q,     drop_d;
  logic [PW-1:0]     rd_ptr_q,   rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0]     count_q,    count_d;
  logic [ADDR_W-1:0] pc_mem_q  [DEPTH];
  logic [DATA_W-1:0] ins_mem_q [DEPTH];

  logic          empty, full, issue, fire, resp_keep, push, q_pop;
  logic [SW-1:0] occ;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  // Queued entries plus outstanding requests must fit, so a response always has a slot.
  assign occ   = SW'(count_q) + SW'(inflight_q);
  assign issue = rst && !branchTaken && (occ < SW'(DEPTH)) && (inflight_q < IW'(MAX_OUT));
  assign fire  = issue && imem.imem_gnt;

  assign imem.imem_req  = issue;
  assign imem.imem_addr = fetch_pc_q;

  assign resp_keep = imem.imem_rvalid && (drop_q == '0) && !branchTaken;
  assign q_pop     = !empty && !freeze && !branchTaken;

`ifdef IF_BYPASS_EN
  logic byp;
  assign byp         = rst && resp_keep && empty;
  assign push        = resp_keep && !(byp && !freeze);
  assign valid       = !empty || byp;
  assign pc          = !empty ? pc_mem_q[rd_ptr_q]
                              : (byp ? resp_pc_q + INSN_BYTES : '0);
  assign instruction = !empty ? ins_mem_q[rd_ptr_q]
                              : (byp ? imem.imem_rdata : '0);
`else
  assign push        = resp_keep;
  assign valid       = !empty;
  assign pc          = !empty ? pc_mem_q[rd_ptr_q]  : '0;
  assign instruction = !empty ? ins_mem_q[rd_ptr_q] : '0;
`endif

  assign fifo_count = count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q + IW'(fire) - IW'(imem.imem_rvalid);
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (branchTaken) begin
      fetch_pc_d = branchAddr;
      resp_pc_d  = branchAddr;
      // Every request still outstanding after this cycle belongs to the old path.
      drop_d     = inflight_q - IW'(imem.imem_rvalid);
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (fire) begin
        fetch_pc_d = fetch_pc_q + INSN_BYTES;
      end
      if (resp_keep) begin
        resp_pc_d = resp_pc_q + INSN_BYTES;
      end
      if (imem.imem_rvalid && (drop_q != '0)) begin
        drop_d = drop_q - IW'(1);
      end
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(q_pop);
      count_d  = count_q + CW'(push) - CW'(q_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]  <= resp_pc_q + INSN_BYTES;
        ins_mem_q[wr_ptr_q] <= imem.imem_rdata;
      end
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    (push && !q_pop) |-> !full);

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_prefetch_stage
// Purpose  : Directed self-checking bench for if_prefetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchAddr = '0;
  logic        freeze = 1'b0;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;
  bit mem_stall = 1'b0;
  logic [31:0] pend_addr[$];

  if_prefetch_stage_if #(.ADDR_W(32), .DATA_W(32)) imem_bus ();

  if_prefetch_stage #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0), .MAX_OUT(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .branchTaken (branchTaken),
    .branchAddr  (branchAddr),
    .freeze      (freeze),
    .imem        (imem_bus),
    .valid       (valid),
    .pc          (pc),
    .instruction (instruction),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: record an accepted request, then present the oldest pending
  // response (memory returns data = ~address) unless stalled.
  task automatic step();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = imem_bus.imem_req && imem_bus.imem_gnt;
    a   = imem_bus.imem_addr;
    @(posedge clk);
    #1;
    if (acc) pend_addr.push_back(a);
    if (!mem_stall && pend_addr.size() > 0) begin
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = ~pend_addr[0];
      void'(pend_addr.pop_front());
    end else begin
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = '0;
    end
    #1;
  endtask

  task automatic hold_reset();
    rst = 1'b0;
    branchTaken = 1'b0;
    freeze = 1'b0;
    mem_stall = 1'b0;
    pend_addr.delete();
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic release_reset();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_bus.imem_gnt    = 1'b1;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;

    // Reset state and streaming with one-cycle memory latency
    hold_reset();
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_req",   32'(imem_bus.imem_req), 32'd0);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_pc",    pc, 32'h0);
    check_eq("rst_instr", instruction, 32'h0);
    release_reset();
    check_eq("s1_req0",  32'(imem_bus.imem_req), 32'd1);
    check_eq("s1_addr0", imem_bus.imem_addr, 32'h0);
    step();
    check_eq("s1_addr1",  imem_bus.imem_addr, 32'h4);
    check_eq("s1_valid1", 32'(valid), 32'd0);
    step();
    check_eq("s1_valid2", 32'(valid), 32'd1);
    check_eq("s1_pc2",    pc, 32'h4);
    check_eq("s1_instr2", instruction, 32'hFFFF_FFFF);
    check_eq("s1_count2", 32'(fifo_count), 32'd1);
    step();
    check_eq("s1_pc3",    pc, 32'h8);
    check_eq("s1_instr3", instruction, 32'hFFFF_FFFB);

    // Freeze: queue fills to 4, requests stop, head held
    freeze = 1'b1;
    repeat (10) step();
    #1;
    check_eq("s2_count", 32'(fifo_count), 32'd4);
    check_eq("s2_req",   32'(imem_bus.imem_req), 32'd0);
    check_eq("s2_pc",    pc, 32'h8);
    check_eq("s2_instr", instruction, 32'hFFFF_FFFB);
    freeze = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("s2_drain_pc",    pc, 32'h8 + 32'(4 * i));
      check_eq("s2_drain_instr", instruction, ~(32'h4 + 32'(4 * i)));
      if (i == 1) begin
        check_eq("s2_drain_count", 32'(fifo_count), 32'd3);
        check_eq("s2_resume_addr", imem_bus.imem_addr, 32'h14);
      end
      step();
    end

    // Branch with two requests in flight
    hold_reset();
    mem_stall = 1'b1;
    release_reset();
    step();
    step();
    check_eq("s3_addr_pre", imem_bus.imem_addr, 32'h8);
    branchTaken = 1'b1;
    branchAddr  = 32'h100;
    mem_stall   = 1'b0;
    #1;
    check_eq("s3_req_br", 32'(imem_bus.imem_req), 32'd0);
    step();
    branchTaken = 1'b0;
    #1;
    check_eq("s3_valid_a", 32'(valid), 32'd0);
    check_eq("s3_addr_tgt", imem_bus.imem_addr, 32'h100);
    step();
    check_eq("s3_valid_b", 32'(valid), 32'd0);
    step();
    check_eq("s3_valid_c", 32'(valid), 32'd0);
    step();
    check_eq("s3_valid_d", 32'(valid), 32'd1);
    check_eq("s3_pc",      pc, 32'h104);
    check_eq("s3_instr",   instruction, 32'hFFFF_FEFF);

    // Branch coincident with rvalid and freeze
    hold_reset();
    release_reset();
    step();
    branchTaken = 1'b1;
    branchAddr  = 32'h200;
    freeze      = 1'b1;
    #1;
    check_eq("s4_req_br", 32'(imem_bus.imem_req), 32'd0);
    step();
    branchTaken = 1'b0;
    #1;
    check_eq("s4_valid_a", 32'(valid), 32'd0);
    check_eq("s4_addr",    imem_bus.imem_addr, 32'h200);
    step();
    step();
    check_eq("s4_valid_b", 32'(valid), 32'd1);
    check_eq("s4_pc",      pc, 32'h204);
    check_eq("s4_instr",   instruction, 32'hFFFF_FDFF);
    check_eq("s4_count",   32'(fifo_count), 32'd1);
    step();
    check_eq("s4_pc_held", pc, 32'h204);
    freeze = 1'b0;

    // Address wrap at the top of the address space
    hold_reset();
    release_reset();
    branchTaken = 1'b1;
    branchAddr  = 32'hFFFF_FFFC;
    #1;
    check_eq("s5_req_br", 32'(imem_bus.imem_req), 32'd0);
    step();
    branchTaken = 1'b0;
    #1;
    check_eq("s5_addr_top", imem_bus.imem_addr, 32'hFFFF_FFFC);
    step();
    check_eq("s5_addr_wrap", imem_bus.imem_addr, 32'h0);
    step();
    check_eq("s5_pc0",    pc, 32'h0);
    check_eq("s5_instr0", instruction, 32'h3);
    step();
    check_eq("s5_pc1",    pc, 32'h4);
    check_eq("s5_instr1", instruction, 32'hFFFF_FFFF);

    // Asynchronous reset mid-operation
    hold_reset();
    release_reset();
    freeze = 1'b1;
    repeat (3) step();
    check_eq("s6_count_pre", 32'(fifo_count), 32'd2);
    check_eq("s6_pc_pre",    pc, 32'h4);
    rst = 1'b0;
    #1;
    check_eq("s6_valid", 32'(valid), 32'd0);
    check_eq("s6_req",   32'(imem_bus.imem_req), 32'd0);
    check_eq("s6_count", 32'(fifo_count), 32'd0);
    check_eq("s6_pc",    pc, 32'h0);
    check_eq("s6_instr", instruction, 32'h0);
    hold_reset();
    release_reset();
    check_eq("s6_req_restart",  32'(imem_bus.imem_req), 32'd1);
    check_eq("s6_addr_restart", imem_bus.imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
